// File: rtl/i2s_slave.sv
// I2S slave: synchronizes external BCLK/LRCLK/SDIN into clk, deframes stereo RX words
// and serializes one buffered stereo TX pair. Optional macro I2S_SLAVE_FRAME_CHECK_EN.
module i2s_slave #(
    parameter int unsigned DSZ = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           i2s_bclk,
    input  logic           i2s_lrclk,
    input  logic           i2s_sdin,
    output logic           i2s_sdout,
    output logic [DSZ-1:0] rx_data,
    output logic           rx_chan,
    output logic           rx_valid,
    input  logic           rx_ready,
    input  logic [DSZ-1:0] tx_left_data,
    input  logic [DSZ-1:0] tx_right_data,
    input  logic           tx_valid,
    output logic           tx_ready,
    output logic           rx_overrun,
    output logic           tx_underrun,
    output logic           frame_err
);

    localparam int unsigned CW = $clog2(DSZ + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(DSZ + 1);

    logic [1:0]     bclk_sync, lrclk_sync, sdin_sync;
    logic           bclk_d;
    logic           lr_prev;
    logic           synced;
    logic [CW-1:0]  rise_cnt;
    logic [DSZ-1:0] rx_shift;
    logic [DSZ-1:0] hold_l, hold_r, right_pend, tx_shift;

    logic           lr_c, sd_c, bclk_rise_c, bclk_fall_c, boundary_c;
    logic           frame_bad_c, deliver_c, left_load_c, right_load_c;
    logic [CW-1:0]  cnt_inc_c;
    logic [DSZ-1:0] word_c;

    // Two-flop synchronizers plus a delayed BCLK copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync  <= 2'b00;
            lrclk_sync <= 2'b00;
            sdin_sync  <= 2'b00;
            bclk_d     <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[0], i2s_bclk};
            lrclk_sync <= {lrclk_sync[0], i2s_lrclk};
            sdin_sync  <= {sdin_sync[0], i2s_sdin};
            bclk_d     <= bclk_sync[1];
        end
    end

    always_comb begin
        lr_c        = lrclk_sync[1];
        sd_c        = sdin_sync[1];
        bclk_rise_c = bclk_sync[1] & ~bclk_d;
        bclk_fall_c = ~bclk_sync[1] & bclk_d;
        boundary_c  = bclk_rise_c && (lr_c != lr_prev);
        cnt_inc_c   = (rise_cnt == CNT_MAX) ? rise_cnt : rise_cnt + CW'(1);
        word_c      = {rx_shift[DSZ-2:0], sd_c};
`ifdef I2S_SLAVE_FRAME_CHECK_EN
        frame_bad_c = (cnt_inc_c != CW'(DSZ));
`else
        frame_bad_c = 1'b0;
`endif
        deliver_c    = boundary_c && synced && !frame_bad_c;
        left_load_c  = boundary_c && synced && !lr_c;
        right_load_c = boundary_c && synced && lr_c;
    end

    // Receive shifter, rise counter and word-select tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_shift <= '0;
            rise_cnt <= '0;
            lr_prev  <= 1'b0;
            synced   <= 1'b0;
        end else if (bclk_rise_c) begin
            rx_shift <= word_c;
            lr_prev  <= lr_c;
            rise_cnt <= boundary_c ? '0 : cnt_inc_c;
            if (boundary_c) begin
                synced <= 1'b1;
            end
        end
    end

    // Receive output register; a new word may replace one being accepted this clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data    <= '0;
            rx_chan    <= 1'b0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (deliver_c) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= word_c;
                    rx_chan  <= lr_prev;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef I2S_SLAVE_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= boundary_c && synced && frame_bad_c;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

    // Transmit holding register, right-channel pending word and output shifter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_l      <= '0;
            hold_r      <= '0;
            right_pend  <= '0;
            tx_shift    <= '0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
            i2s_sdout   <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (tx_valid && tx_ready) begin
                hold_l   <= tx_left_data;
                hold_r   <= tx_right_data;
                tx_ready <= 1'b0;
            end
            if (left_load_c) begin
                if (!tx_ready) begin
                    tx_shift   <= hold_l;
                    right_pend <= hold_r;
                    tx_ready   <= 1'b1;
                end else begin
                    tx_shift    <= '0;
                    right_pend  <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (right_load_c) begin
                tx_shift <= right_pend;
            end else if (bclk_fall_c && synced) begin
                i2s_sdout <= tx_shift[DSZ-1];
                tx_shift  <= {tx_shift[DSZ-2:0], 1'b0};
            end
        end
    end

endmodule
